// File: rtl/result_word_buffer.sv
// Packs accepted result bits LSB-first into WIDTH-bit words and queues them in a DEPTH-entry FIFO.
// Optional macro RESULT_BUF_STATS_EN adds a saturating count of accepted 1-bits on o_stat_ones.
module result_word_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_in_valid,
    input  logic             i_in_bit,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_out_data,
`ifdef RESULT_BUF_STATS_EN
    input  logic             i_out_ready,
    output logic [15:0]      o_stat_ones
`else
    input  logic             i_out_ready
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [BW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_last;
    logic             w_accept;
    logic             w_pop;
    logic             w_push;
    logic [WIDTH-1:0] w_word;

    // in_ready depends only on registered state; a full FIFO stalls only the word-completing bit.
    assign w_last      = (r_bit_cnt == LAST_BIT);
    assign o_in_ready  = !(w_last && (r_count == FULL_CNT));
    assign o_out_valid = (r_count != '0);
    assign o_out_data  = o_out_valid ? r_mem[r_rd_ptr] : '0;

    // Clear wins over any accept or pop in the same cycle.
    assign w_accept = i_in_valid & o_in_ready & ~i_clr;
    assign w_pop    = o_out_valid & i_out_ready & ~i_clr;
    assign w_push   = w_accept & w_last;

    always_comb begin
        w_word            = r_shift;
        w_word[r_bit_cnt] = i_in_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (i_clr) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
                r_shift   <= w_word;
            end
        end
    end

    // Word storage is deliberately left unreset; out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef RESULT_BUF_STATS_EN
    logic [15:0] r_stat_ones;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_ones <= '0;
        end else if (i_clr) begin
            r_stat_ones <= '0;
        end else if (w_accept && i_in_bit && (r_stat_ones != 16'hFFFF)) begin
            r_stat_ones <= r_stat_ones + 16'd1;
        end
    end

    assign o_stat_ones = r_stat_ones;
`else
`endif

endmodule

// File: tb/tb_result_word_buffer.sv
// Self-checking bench for result_word_buffer: directed scenarios plus random traffic,
// checked by a queue-based reference model and a decoupled pop monitor.
module tb_result_word_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             inValid;
    logic             inBit;
    logic             inReady;
    logic             outValid;
    logic [WIDTH-1:0] outData;
    logic             outReady;
`ifdef RESULT_BUF_STATS_EN
    logic [15:0]      statOnes;
`endif

    result_word_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (clr),
        .i_in_valid  (inValid),
        .i_in_bit    (inBit),
        .o_in_ready  (inReady),
        .o_out_valid (outValid),
        .o_out_data  (outData),
`ifdef RESULT_BUF_STATS_EN
        .i_out_ready (outReady),
        .o_stat_ones (statOnes)
`else
        .i_out_ready (outReady)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: words currently held by the buffer, bits of the word in progress,
    // and the scoreboard of words still expected at the consumer.
    logic [WIDTH-1:0] modelFifo[$];
    logic [WIDTH-1:0] scoreQ[$];
    bit               pending[$];
    int               modelOnes = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        modelFifo.delete();
        scoreQ.delete();
        pending.delete();
        modelOnes = 0;
    endtask

    // One cycle: check outputs against the model, drive inputs, predict the next edge.
    task automatic applyStimulus(input bit v, input bit b, input bit rdy, input bit c);
        bit               expReady;
        bit               accept;
        logic [WIDTH-1:0] word;
        expReady = !(pending.size() == WIDTH - 1 && modelFifo.size() == DEPTH);
        checkOutput("in_ready", inReady, expReady);
        checkOutput("out_valid", outValid, modelFifo.size() != 0);
        if (modelFifo.size() != 0) checkOutput("head_data", outData, modelFifo[0]);
        else                       checkOutput("idle_data", outData, 0);
`ifdef RESULT_BUF_STATS_EN
        checkOutput("stat_ones", statOnes, modelOnes);
`endif
        inValid  = v;
        inBit    = v ? b : 1'($urandom_range(0, 1));
        outReady = rdy;
        clr      = c;
        if (c) begin
            resetModel();
        end else begin
            accept = v && expReady;
            if (rdy && modelFifo.size() != 0) void'(modelFifo.pop_front());
            if (accept) begin
                if (b && modelOnes < 16'hFFFF) modelOnes++;
                pending.push_back(b);
                if (pending.size() == WIDTH) begin
                    for (int i = 0; i < WIDTH; i++) word[i] = pending[i];
                    modelFifo.push_back(word);
                    scoreQ.push_back(word);
                    pending.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pushWord(input logic [WIDTH-1:0] w, input bit rdy);
        for (int i = 0; i < WIDTH; i++) applyStimulus(1'b1, w[i], rdy, 1'b0);
    endtask

    task automatic drain();
        repeat (DEPTH + 2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Monitor: every real pop must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (rst_n && !clr && outValid && outReady) begin
            if (scoreQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pop actual=%0h expected=none at %0t", outData, $time);
            end else begin
                checkOutput("pop_data", outData, scoreQ.pop_front());
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] singleWord;
        logic [WIDTH-1:0] fifthWord;
        singleWord = 8'h8D;
        fifthWord  = 8'hA5;

        rst_n    = 1'b0;
        clr      = 1'b0;
        inValid  = 1'b1;
        inBit    = 1'b1;
        outReady = 1'b0;
        #3;
        checkOutput("reset_out_valid", outValid, 0);
        checkOutput("reset_in_ready", inReady, 1);
        checkOutput("reset_out_data", outData, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_hold_valid", outValid, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        inValid = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Single word with the consumer always ready.
        pushWord(singleWord, 1'b1);
        checkOutput("single_word_data", outData, 8'h8D);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("single_word_gone", outValid, 0);

        // 8D then FF gives twelve ones, then clear.
        pushWord(8'hFF, 1'b1);
`ifdef RESULT_BUF_STATS_EN
        checkOutput("stats_twelve", statOnes, 12);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Full FIFO stalls only the completing bit.
        for (int w = 1; w <= DEPTH; w++) pushWord(WIDTH'(w), 1'b0);
        for (int i = 0; i < WIDTH - 1; i++) applyStimulus(1'b1, fifthWord[i], 1'b0, 1'b0);
        checkOutput("full_stall_ready", inReady, 0);
        repeat (2) applyStimulus(1'b1, fifthWord[WIDTH-1], 1'b0, 1'b0);
        applyStimulus(1'b1, fifthWord[WIDTH-1], 1'b1, 1'b0);
        checkOutput("unstall_ready", inReady, 1);
        applyStimulus(1'b1, fifthWord[WIDTH-1], 1'b0, 1'b0);
        drain();

        // Clear with two words and three bits pending, pop requested in the same cycle.
        pushWord(8'h3C, 1'b0);
        pushWord(8'hC3, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("clear_out_valid", outValid, 0);
        pushWord(8'hFF, 1'b0);
        checkOutput("clear_clean_word", outData, 8'hFF);
        drain();

        // Asynchronous reset between edges after five bits of a second word.
        pushWord(8'h5A, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", outValid, 0);
        checkOutput("async_out_data", outData, 0);
        checkOutput("async_in_ready", inReady, 1);
        resetModel();
        inValid  = 1'b0;
        outReady = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pushWord(8'h96, 1'b0);
        checkOutput("async_clean_word", outData, 8'h96);
        drain();

        // Random traffic with occasional clears.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 60) == 0));
        end
        drain();
        checkOutput("scoreboard_empty", scoreQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
